// File: rtl/sopc_cpu_div_cell.sv
// sopc_cpu_div_cell
// Iterative radix-2 restoring divider for the Nios II div/divu A-stage cell.
// Operands are made non-negative on entry. One quotient bit is resolved per
// cycle, MSB first. Signs are restored and special cases applied in a final
// fix-up cycle. Latency from an accepted start to done is always WIDTH+2 cycles.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for A_div_start; outputs hold the last result
//   CALC  | WIDTH shift/subtract iterations, one quotient bit per cycle
//   FIX   | sign restore + special-case override, then done pulse
module sopc_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A_div_start,
    input  logic             A_div_signed,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quot,
    output logic [WIDTH-1:0] A_div_rem
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] dvd;       // dividend magnitude; quotient bits shift in at the LSB
    logic [WIDTH-1:0] dvs;       // divisor magnitude
    logic [WIDTH-1:0] prem;      // partial remainder, always < dvs
    logic [WIDTH-1:0] src1_raw;  // original dividend, returned as-is on divide by zero
    logic             neg_quot;
    logic             neg_rem;
    logic             div_zero;
    logic             ovf;

    logic             src1_neg;
    logic             src2_neg;
    logic [WIDTH-1:0] src1_abs;
    logic [WIDTH-1:0] src2_abs;
    logic [WIDTH:0]   prem_shift;
    logic             qbit;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes; abs(MIN_VAL) wraps to MIN_VAL, read as unsigned 2^(WIDTH-1)
    always_comb begin
        src1_neg = A_div_signed & A_div_src1[WIDTH-1];
        src2_neg = A_div_signed & A_div_src2[WIDTH-1];
        src1_abs = src1_neg ? (~A_div_src1 + 1'b1) : A_div_src1;
        src2_abs = src2_neg ? (~A_div_src2 + 1'b1) : A_div_src2;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The difference is exact in WIDTH bits whenever it is taken, since it is < dvs.
    always_comb begin
        prem_shift = {prem, dvd[WIDTH-1]};
        qbit       = (prem_shift >= {1'b0, dvs});
        prem_next  = qbit ? (prem_shift[WIDTH-1:0] - dvs) : prem_shift[WIDTH-1:0];
    end

    // Final result: sign restore, then the special cases take precedence
    always_comb begin
        quot_fix = neg_quot ? (~dvd + 1'b1) : dvd;
        rem_fix  = neg_rem  ? (~prem + 1'b1) : prem;
        if (div_zero) begin
            quot_fix = ALL_ONES;
            rem_fix  = src1_raw;
        end else if (ovf) begin
            quot_fix = MIN_VAL;
            rem_fix  = '0;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            dvd        <= '0;
            dvs        <= '0;
            prem       <= '0;
            src1_raw   <= '0;
            neg_quot   <= 1'b0;
            neg_rem    <= 1'b0;
            div_zero   <= 1'b0;
            ovf        <= 1'b0;
            A_div_busy <= 1'b0;
            A_div_done <= 1'b0;
            A_div_quot <= '0;
            A_div_rem  <= '0;
        end else begin
            A_div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (A_div_start) begin
                        dvd        <= src1_abs;
                        dvs        <= src2_abs;
                        prem       <= '0;
                        src1_raw   <= A_div_src1;
                        neg_quot   <= src1_neg ^ src2_neg;
                        neg_rem    <= src1_neg;
                        div_zero   <= (A_div_src2 == '0);
                        ovf        <= A_div_signed && (A_div_src1 == MIN_VAL)
                                      && (A_div_src2 == ALL_ONES);
                        count      <= '0;
                        A_div_busy <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    prem  <= prem_next;
                    dvd   <= {dvd[WIDTH-2:0], qbit};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    A_div_quot <= quot_fix;
                    A_div_rem  <= rem_fix;
                    A_div_done <= 1'b1;
                    A_div_busy <= 1'b0;
                    count      <= '0;
                    state      <= IDLE;
                end
                default: begin
                    A_div_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sopc_cpu_div_cell.sv
// Bench for sopc_cpu_div_cell: vector table, corner-case sequences and random
// pairs. Expected results are queued at issue time and compared on done.
module tb_sopc_cpu_div_cell;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sgn;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic         sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           cyc0;
    } exp_t;

    exp_t sb[$];

    sopc_cpu_div_cell #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .A_div_start  (start),
        .A_div_signed (sgn),
        .A_div_src1   (src1),
        .A_div_src2   (src2),
        .A_div_busy   (busy),
        .A_div_done   (done),
        .A_div_quot   (quot),
        .A_div_rem    (rem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quot", quot, e.q);
                check("rem", rem, e.r);
                check("latency", W'(cyc - e.cyc0), W'(LAT));
            end
        end
    end

    function automatic void ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else if (sg) begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called at a negedge: present a start for the following rising edge
    task automatic issue(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r);
        exp_t e;
        start = 1'b1;
        sgn   = sg;
        src1  = a;
        src2  = b;
        e.q = q;
        e.r = r;
        e.cyc0 = cyc;
        sb.push_back(e);
    endtask

    // Walk the op to done; optionally pokes a start while busy at cycle poke_at
    task automatic finish_op(input int poke_at);
        int lat;
        int busy_err;
        lat = 0;
        busy_err = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            start = (lat == poke_at);
            if (lat == poke_at) begin
                sgn  = 1'b0;
                src1 = 32'd999;
                src2 = 32'd3;
            end
            if (done) break;
            if (lat < LAT && !busy) busy_err++;
        end
        check("busy_during_op", W'(busy_err), '0);
        check("done_cycle", W'(lat), W'(LAT));
        check("busy_at_done", W'(busy), '0);
        if (lat >= 60) sb.delete();
    endtask

    vec_t tbl[$];

    initial begin
        logic [W-1:0] q, r, a, b;
        logic sg;

        tbl.push_back('{1'b0, 32'd100,       32'd7,         32'd14,        32'd2});
        tbl.push_back('{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE});
        tbl.push_back('{1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2});
        tbl.push_back('{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE});
        tbl.push_back('{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0});
        tbl.push_back('{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5});
        tbl.push_back('{1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB});
        tbl.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0});
        tbl.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
        tbl.push_back('{1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0});
        tbl.push_back('{1'b0, 32'd7,         32'd100,       32'd0,         32'd7});
        tbl.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0});
        tbl.push_back('{1'b1, 32'hFFFF_FFF9, 32'd100,       32'd0,         32'hFFFF_FFF9});

        reset = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        src1  = '0;
        src2  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_quot", quot, '0);
        check("reset_rem", rem, '0);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            issue(tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r);
            finish_op(0);
            @(negedge clk);
        end

        // Starts while busy are ignored; no second done afterwards
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        finish_op(10);
        repeat (40) @(negedge clk);

        // Back-to-back: second start presented in the done cycle
        issue(1'b0, 32'd1000, 32'd9, 32'd111, 32'd1);
        finish_op(0);
        issue(1'b1, 32'hFFFF_FC18, 32'd9, 32'hFFFF_FF91, 32'hFFFF_FFFF);
        finish_op(0);
        @(negedge clk);

        // Reset mid-operation aborts: no done, outputs zeroed
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        repeat (20) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("abort_busy", W'(busy), '0);
        check("abort_quot", quot, '0);
        check("abort_rem", rem, '0);
        repeat (40) @(negedge clk);

        // Random pairs against the reference model
        for (int k = 0; k < 300; k++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom();
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom() >> $urandom_range(0, 31);
            endcase
            if (k % 37 == 0) a = 32'h8000_0000;
            ref_div(sg, a, b, q, r);
            issue(sg, a, b, q, r);
            finish_op(0);
        end
        @(negedge clk);
        check("scoreboard_empty", W'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
